// File: rtl/stream_dwc_upsize_if.sv
// Valid/ready stream bundle for the width up-converter:
// narrow input beats in, packed output words out.
interface stream_dwc_upsize_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 24
);
   logic [IN_W-1:0]  i_d;
   logic             i_v;
   logic             i_r;
   logic [OUT_W-1:0] o_d;
   logic             o_v;
   logic             o_r;

   modport slave (
      input  i_d, i_v, o_r,
      output i_r, o_d, o_v
   );

   modport master (
      output i_d, i_v, o_r,
      input  i_r, o_d, o_v
   );
endinterface

// File: rtl/stream_dwc_upsize.sv
// Frame-aware stream up-converter: packs RATIO narrow beats LSB-first
// into one wide word; a short frame tail is emitted zero-padded.
module stream_dwc_upsize #(
   parameter int IN_W        = 8,
   parameter int RATIO       = 3,
   parameter int OUT_W       = IN_W * RATIO,
   parameter int FRAME_BEATS = 288,
   parameter int CNT_W       = 9
) (
   input  logic                clock,
   input  logic                reset,
   stream_dwc_upsize_if.slave  s,
   output logic [15:0]         frame_cnt,
   output logic [CNT_W-1:0]    beat_idx
);
   localparam int SW = (RATIO > 1) ? $clog2(RATIO) : 1;

   if (OUT_W != IN_W * RATIO) begin : g_bad_out_w
      $error("OUT_W must equal IN_W*RATIO");
   end
   if (RATIO < 1 || FRAME_BEATS < 1) begin : g_bad_ratio
      $error("RATIO and FRAME_BEATS must be at least 1");
   end
   if ((64'd1 << CNT_W) <= 64'(FRAME_BEATS)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for FRAME_BEATS");
   end

   logic [OUT_W-1:0] acc_q, acc_d, acc_wr;
   logic [SW-1:0]    slot_q, slot_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [15:0]      frame_q, frame_d;
   logic [OUT_W-1:0] od_q, od_d;
   logic             ov_q, ov_d;
   logic             last_q, last_d;
   logic             last_beat;
   logic             closing;
   logic             ready;
   logic             take;

   always_comb begin
      last_beat = (beat_q == CNT_W'(FRAME_BEATS - 1));
      closing   = (slot_q == SW'(RATIO - 1)) || last_beat;
      // Only a word-closing beat needs the output register free.
      ready     = !(closing && ov_q && !s.o_r);
      take      = s.i_v && ready;

      acc_wr = acc_q;
      if (take) begin
         acc_wr[int'(slot_q) * IN_W +: IN_W] = s.i_d;
      end

      acc_d   = acc_q;
      slot_d  = slot_q;
      beat_d  = beat_q;
      frame_d = frame_q;
      od_d    = od_q;
      ov_d    = ov_q;
      last_d  = last_q;

      if (ov_q && s.o_r) begin
         ov_d = 1'b0;
         if (last_q) begin
            frame_d = frame_q + 16'd1;
         end
      end

      if (take) begin
         beat_d = last_beat ? '0 : beat_q + 1'b1;
         if (closing) begin
            od_d   = acc_wr;
            ov_d   = 1'b1;
            last_d = last_beat;
            acc_d  = '0;
            slot_d = '0;
         end else begin
            acc_d  = acc_wr;
            slot_d = slot_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q   <= '0;
         slot_q  <= '0;
         beat_q  <= '0;
         frame_q <= '0;
         od_q    <= '0;
         ov_q    <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         slot_q  <= slot_d;
         beat_q  <= beat_d;
         frame_q <= frame_d;
         od_q    <= od_d;
         ov_q    <= ov_d;
         last_q  <= last_d;
      end
   end

   assign s.i_r     = ready;
   assign s.o_d     = od_q;
   assign s.o_v     = ov_q;
   assign frame_cnt = frame_q;
   assign beat_idx  = beat_q;
endmodule
